// File: rtl/ring_alloc.sv
// In-order slot allocator for a DEPTH-entry circular buffer: grants indices from
// a wrapping head pointer and reclaims them oldest-first through a wrapping tail.
module ring_alloc #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned WIDTH     = (DEPTH == 1) ? 1 : $clog2(DEPTH),
   parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_valid,
   output logic                 alloc_ready,
   output logic [WIDTH-1:0]     alloc_idx,
   input  logic                 retire_valid,
   output logic                 retire_ready,
   output logic [WIDTH-1:0]     retire_idx,
   output logic [CNT_WIDTH-1:0] occupancy,
   output logic                 empty,
   output logic                 full,
   input  logic                 flush,
   output logic                 err
);

   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_err;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_alloc_fire;
   logic                 w_retire_fire;

   // Readies look only at registered state and flush, so a retire never frees
   // a slot for an alloc in the same cycle.
   assign w_empty       = (r_cnt == '0);
   assign w_full        = (r_cnt == FULL_CNT);
   assign alloc_ready   = !w_full && !flush;
   assign retire_ready  = !w_empty && !flush;
   assign w_alloc_fire  = alloc_valid && alloc_ready;
   assign w_retire_fire = retire_valid && retire_ready;

   assign occupancy = r_cnt;
   assign empty     = w_empty;
   assign full      = w_full;
   assign err       = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (retire_valid && w_empty && !flush)
            r_err <= 1'b1;
         if (flush)
            r_cnt <= '0;
         else if (w_alloc_fire && !w_retire_fire)
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         else if (!w_alloc_fire && w_retire_fire)
            r_cnt <= r_cnt - CNT_WIDTH'(1);
      end
   end

   generate
      if (DEPTH == 1) begin : g_single
         assign alloc_idx  = '0;
         assign retire_idx = '0;
      end else begin : g_ring
         localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(DEPTH - 1);

         logic [WIDTH-1:0] r_head;
         logic [WIDTH-1:0] r_tail;

         // Explicit wrap compare keeps non-power-of-two depths correct.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_head <= '0;
               r_tail <= '0;
            end else if (flush) begin
               r_head <= '0;
               r_tail <= '0;
            end else begin
               if (w_alloc_fire)
                  r_head <= (r_head == LAST_IDX) ? '0 : r_head + WIDTH'(1);
               if (w_retire_fire)
                  r_tail <= (r_tail == LAST_IDX) ? '0 : r_tail + WIDTH'(1);
            end
         end

         assign alloc_idx  = r_head;
         assign retire_idx = r_tail;
      end
   endgenerate

endmodule

// File: tb/tb_ring_alloc.sv
// Randomised and directed checks of ring_alloc at DEPTH 8, 5 and 1 against
// queue-based reference models of the allocated-slot list.
module tb_ring_alloc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // DEPTH=8 instance
   logic       av8 = 0, rv8 = 0, fl8 = 0, ar8, rr8, em8, fu8, er8;
   logic [2:0] ai8, ri8;
   logic [3:0] oc8;
   // DEPTH=5 instance
   logic       av5 = 0, rv5 = 0, fl5 = 0, ar5, rr5, em5, fu5, er5;
   logic [2:0] ai5, ri5, oc5;
   // DEPTH=1 instance
   logic       av1 = 0, rv1 = 0, fl1 = 0, ar1, rr1, em1, fu1, er1;
   logic [0:0] ai1, ri1, oc1;

   ring_alloc #(.DEPTH(8)) u_d8 (
      .clk(clk), .rst(rst), .alloc_valid(av8), .alloc_ready(ar8), .alloc_idx(ai8),
      .retire_valid(rv8), .retire_ready(rr8), .retire_idx(ri8), .occupancy(oc8),
      .empty(em8), .full(fu8), .flush(fl8), .err(er8));
   ring_alloc #(.DEPTH(5)) u_d5 (
      .clk(clk), .rst(rst), .alloc_valid(av5), .alloc_ready(ar5), .alloc_idx(ai5),
      .retire_valid(rv5), .retire_ready(rr5), .retire_idx(ri5), .occupancy(oc5),
      .empty(em5), .full(fu5), .flush(fl5), .err(er5));
   ring_alloc #(.DEPTH(1)) u_d1 (
      .clk(clk), .rst(rst), .alloc_valid(av1), .alloc_ready(ar1), .alloc_idx(ai1),
      .retire_valid(rv1), .retire_ready(rr1), .retire_idx(ri1), .occupancy(oc1),
      .empty(em1), .full(fu1), .flush(fl1), .err(er1));

   logic [15:0] act8;
   logic [13:0] act5;
   logic [7:0]  act1;
   assign act8 = {ai8, ri8, oc8, ar8, rr8, em8, fu8, er8};
   assign act5 = {ai5, ri5, oc5, ar5, rr5, em5, fu5, er5};
   assign act1 = {ai1, ri1, oc1, ar1, rr1, em1, fu1, er1};

   // Reference models: a queue holds the allocated indices, oldest first.
   int q8[$], q5[$], q1[$];
   int h8 = 0, h5 = 0, h1 = 0;
   bit e8 = 0, e5 = 0, e1 = 0;
   bit a8, r8, a5, r5, a1, r1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q8.delete(); h8 = 0; e8 = 0;
      end else if (fl8) begin
         q8.delete(); h8 = 0;
      end else begin
         if (rv8 && q8.size() == 0) e8 = 1;
         a8 = av8 && q8.size() < 8;
         r8 = rv8 && q8.size() > 0;
         if (r8) void'(q8.pop_front());
         if (a8) begin q8.push_back(h8); h8 = (h8 + 1) % 8; end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q5.delete(); h5 = 0; e5 = 0;
      end else if (fl5) begin
         q5.delete(); h5 = 0;
      end else begin
         if (rv5 && q5.size() == 0) e5 = 1;
         a5 = av5 && q5.size() < 5;
         r5 = rv5 && q5.size() > 0;
         if (r5) void'(q5.pop_front());
         if (a5) begin q5.push_back(h5); h5 = (h5 + 1) % 5; end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q1.delete(); h1 = 0; e1 = 0;
      end else if (fl1) begin
         q1.delete(); h1 = 0;
      end else begin
         if (rv1 && q1.size() == 0) e1 = 1;
         a1 = av1 && q1.size() < 1;
         r1 = rv1 && q1.size() > 0;
         if (r1) void'(q1.pop_front());
         if (a1) begin q1.push_back(h1); h1 = (h1 + 1) % 1; end
      end
   end

   function automatic int t8(); return (q8.size() > 0) ? q8[0] : h8; endfunction
   function automatic int t5(); return (q5.size() > 0) ? q5[0] : h5; endfunction
   function automatic int t1(); return (q1.size() > 0) ? q1[0] : h1; endfunction

   function automatic logic [15:0] exp8();
      return {3'(h8), 3'(t8()), 4'(q8.size()), (q8.size() < 8) && !fl8,
              (q8.size() > 0) && !fl8, q8.size() == 0, q8.size() == 8, e8};
   endfunction
   function automatic logic [13:0] exp5();
      return {3'(h5), 3'(t5()), 3'(q5.size()), (q5.size() < 5) && !fl5,
              (q5.size() > 0) && !fl5, q5.size() == 0, q5.size() == 5, e5};
   endfunction
   function automatic logic [7:0] exp1();
      return {1'(h1), 1'(t1()), 1'(q1.size()), (q1.size() < 1) && !fl1,
              (q1.size() > 0) && !fl1, q1.size() == 0, q1.size() == 1, e1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      total++; if (act8 !== 16'b000_000_0000_1_0_1_0_0) begin bad++;
         $display("FAIL reset8 act=%h exp=%h", act8, 16'b000_000_0000_1_0_1_0_0); end
      total++; if (act5 !== 14'b000_000_000_1_0_1_0_0) begin bad++;
         $display("FAIL reset5 act=%h exp=%h", act5, 14'b000_000_000_1_0_1_0_0); end
      total++; if (act1 !== 8'b0_0_0_1_0_1_0_0) begin bad++;
         $display("FAIL reset1 act=%h exp=%h", act1, 8'b0_0_0_1_0_1_0_0); end
      #3 rst = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      av8 = 1;
      for (int i = 0; i < 8; i++) begin
         total++; if (int'(ai8) !== i) begin bad++;
            $display("FAIL fill_idx act=%0d exp=%0d", ai8, i); end
         tick();
      end
      total++; if ({fu8, ar8, oc8} !== {1'b1, 1'b0, 4'd8}) begin bad++;
         $display("FAIL fill_full full=%b ready=%b occ=%0d exp 1 0 8", fu8, ar8, oc8); end
      tick();
      total++; if (ai8 !== 3'd0 || oc8 !== 4'd8) begin bad++;
         $display("FAIL ninth_alloc idx=%0d occ=%0d exp 0 8", ai8, oc8); end
      av8 = 0;
   endtask

   task automatic test_drain();
      rv8 = 1;
      for (int i = 0; i < 8; i++) begin
         total++; if (int'(ri8) !== i) begin bad++;
            $display("FAIL drain_idx act=%0d exp=%0d", ri8, i); end
         tick();
      end
      rv8 = 0;
      total++; if ({em8, rr8, oc8} !== {1'b1, 1'b0, 4'd0}) begin bad++;
         $display("FAIL drain_empty empty=%b ready=%b occ=%0d exp 1 0 0", em8, rr8, oc8); end
   endtask

   task automatic test_wrap();
      int allocs = 0;
      int cyc = 0;
      while (allocs < 12 && cyc < 80) begin
         av5 = (q5.size() < 3);
         rv5 = (q5.size() > 0) && ($urandom_range(0, 1) == 1 || q5.size() == 3);
         #0;
         if (av5 && ar5) begin
            total++; if (int'(ai5) !== allocs % 5) begin bad++;
               $display("FAIL wrap_idx act=%0d exp=%0d", ai5, allocs % 5); end
            allocs++;
         end
         total++; if ((int'(ri5) + int'(oc5)) % 5 !== int'(ai5) || oc5 > 3'd3) begin bad++;
            $display("FAIL wrap_inv tail=%0d occ=%0d head=%0d", ri5, oc5, ai5); end
         tick();
         cyc++;
      end
      av5 = 0; rv5 = 0;
      total++; if (allocs !== 12) begin bad++;
         $display("FAIL wrap_budget allocs=%0d exp=12", allocs); end
   endtask

   task automatic test_simul();
      int h0, t0, hf;
      av8 = 1;
      repeat (3) tick();
      h0 = h8; t0 = t8();
      rv8 = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (oc8 !== 4'd3) begin bad++;
            $display("FAIL simul_occ act=%0d exp=3", oc8); end
      end
      total++; if (int'(ai8) !== (h0 + 4) % 8 || int'(ri8) !== (t0 + 4) % 8) begin bad++;
         $display("FAIL simul_ptr head=%0d tail=%0d exp %0d %0d", ai8, ri8, (h0+4)%8, (t0+4)%8); end
      rv8 = 0;
      repeat (5) tick();
      hf = h8;
      rv8 = 1;
      #0;
      total++; if ({fu8, ar8, rr8} !== 3'b101) begin bad++;
         $display("FAIL full_both full/ar/rr=%b exp=101", {fu8, ar8, rr8}); end
      tick();
      total++; if (oc8 !== 4'd7 || int'(ai8) !== hf) begin bad++;
         $display("FAIL full_both_after occ=%0d head=%0d exp 7 %0d", oc8, ai8, hf); end
      av8 = 0; rv8 = 0;
   endtask

   task automatic test_flush();
      rv8 = 1;
      repeat (3) tick();
      rv8 = 0;
      total++; if (oc8 !== 4'd4) begin bad++;
         $display("FAIL preflush_occ act=%0d exp=4", oc8); end
      fl8 = 1; av8 = 1; rv8 = 1;
      #1;
      total++; if ({ar8, rr8} !== 2'b00) begin bad++;
         $display("FAIL flush_ready ar/rr=%b exp=00", {ar8, rr8}); end
      tick();
      fl8 = 0; av8 = 0; rv8 = 0;
      #0;
      total++; if (act8 !== exp8() || {ai8, ri8, oc8, em8} !== 11'b000_000_0000_1) begin bad++;
         $display("FAIL flush_after act=%h exp=%h", act8, exp8()); end
   endtask

   task automatic test_err();
      fl5 = 1; tick(); fl5 = 0;
      rv5 = 1; tick(); rv5 = 0;
      total++; if (er5 !== 1'b1 || oc5 !== 3'd0) begin bad++;
         $display("FAIL err_set err=%b occ=%0d exp 1 0", er5, oc5); end
      fl5 = 1; tick(); fl5 = 0;
      total++; if (er5 !== 1'b1) begin bad++;
         $display("FAIL err_after_flush act=%b exp=1", er5); end
      av8 = 1; repeat (2) tick(); av8 = 0;
      #3 rst = 1'b1;
      #1;
      total++; if (er5 !== 1'b0 || oc8 !== 4'd0 || ai8 !== 3'd0) begin bad++;
         $display("FAIL async_rst err=%b occ=%0d head=%0d exp 0 0 0", er5, oc8, ai8); end
      #3 rst = 1'b0;
      tick();
   endtask

   task automatic test_depth1();
      for (int i = 0; i < 8; i++) begin
         av1 = (i % 2 == 0); rv1 = (i % 2 == 1);
         #0;
         total++; if (ai1 !== 1'b0 || ri1 !== 1'b0 || act1 !== exp1()) begin bad++;
            $display("FAIL depth1 cyc=%0d act=%h exp=%h", i, act1, exp1()); end
         tick();
      end
      av1 = 1; rv1 = 0; tick();
      total++; if ({fu1, ar1, oc1} !== 3'b101) begin bad++;
         $display("FAIL depth1_full full/ar/occ=%b exp=101", {fu1, ar1, oc1}); end
      av1 = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         av8 = 1'($urandom_range(0, 1)); rv8 = 1'($urandom_range(0, 1));
         fl8 = ($urandom_range(0, 19) == 0);
         av5 = 1'($urandom_range(0, 1)); rv5 = ($urandom_range(0, 2) == 0);
         fl5 = ($urandom_range(0, 19) == 0);
         av1 = 1'($urandom_range(0, 1)); rv1 = 1'($urandom_range(0, 1));
         fl1 = ($urandom_range(0, 19) == 0);
         #1;
         total++; if (act8 !== exp8()) begin bad++;
            $display("FAIL rand8 cyc=%0d act=%h exp=%h", i, act8, exp8()); end
         total++; if (act5 !== exp5()) begin bad++;
            $display("FAIL rand5 cyc=%0d act=%h exp=%h", i, act5, exp5()); end
         total++; if (act1 !== exp1()) begin bad++;
            $display("FAIL rand1 cyc=%0d act=%h exp=%h", i, act1, exp1()); end
         total++; if ((int'(ri5) + int'(oc5)) % 5 !== int'(ai5)) begin bad++;
            $display("FAIL rand_inv5 tail=%0d occ=%0d head=%0d", ri5, oc5, ai5); end
         tick();
      end
      av8 = 0; rv8 = 0; fl8 = 0; av5 = 0; rv5 = 0; fl5 = 0; av1 = 0; rv1 = 0; fl1 = 0;
   endtask

   initial begin
      #12 rst = 1'b0;
      tick();
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simul();
      test_flush();
      test_err();
      test_depth1();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ring_alloc.md
# ring_alloc

In-order slot allocator for a circular buffer of DEPTH entries: it hands out slot indices from a wrapping head pointer and reclaims them, oldest first, through a wrapping tail pointer. It is the consuming counterpart to the wrapping tick counter. The allocator issues indices, and retirement returns them in the same order. It sits beside the reorder and issue queues, which use alloc_idx and retire_idx to address their storage.

## Interface
- DEPTH, default 8: number of slots, ≥1, any value (power of two not required).
- WIDTH, default DEPTH==1 ? 1 : $clog2(DEPTH): index width.
- CNT_WIDTH, default $clog2(DEPTH+1): occupancy width.

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- alloc_valid  in  1  requester wants a slot
- alloc_ready  out  1  a slot can be granted this cycle
- alloc_idx  out  WIDTH  index granted when the alloc handshake fires
- retire_valid  in  1  release the oldest allocated slot
- retire_ready  out  1  at least one slot is allocated
- retire_idx  out  WIDTH  index of the oldest allocated slot
- occupancy  out  CNT_WIDTH  number of allocated slots, 0..DEPTH
- empty  out  1  occupancy == 0
- full  out  1  occupancy == DEPTH
- flush  in  1  synchronous clear of all allocations
- err  out  1  sticky flag: retire requested while empty

## Operation
- State:
  - head: next slot to allocate.
  - tail: oldest allocated slot.
  - cnt: occupancy.
  - err.
- Derived outputs:
  - alloc_idx = head; retire_idx = tail; occupancy = cnt.
  - empty = (cnt==0); full = (cnt==DEPTH).
  - alloc_ready = !full && !flush.
  - retire_ready = !empty && !flush.
- Handshakes:
  - alloc_fire = alloc_valid && alloc_ready.
  - retire_fire = retire_valid && retire_ready.
- Pointer advance:
  - On alloc_fire, head advances by 1. On retire_fire, tail advances by 1.
  - Each pointer wraps DEPTH-1 → 0. The wrap is an explicit compare, never reliance on WIDTH overflow.
- Count update:
  - alloc_fire only: cnt+1.
  - retire_fire only: cnt-1.
  - Both, or neither: cnt unchanged.
- Simultaneous alloc and retire:
  - Both pointers advance in the same cycle.
  - This is legal when full: alloc_ready is already 0, so only the retire takes effect.
  - This is legal when empty: retire_ready is 0, so only the alloc takes effect.
- No bypass: a retire in cycle N does not raise alloc_ready in cycle N. Both ready signals depend only on registered state and flush.
- flush:
  - Next cycle, head = tail = cnt = 0.
  - flush dominates: no handshake fires in a flush cycle, because both readies are forced low.
  - err is unaffected.
- err:
  - Set when retire_valid && empty && !flush.
  - Held until rst; there is no other clear.
  - A retire_valid while empty otherwise has no effect.
- DEPTH==1:
  - head and tail are tied to 0; only cnt toggles between 0 and 1.
  - Unused pointer logic must not generate lint-visible dead registers.
- Invariant: (tail + cnt) mod DEPTH == head at all times. The verification bench asserts it.

## Timing
- Reset (asynchronous, immediate):
  - head = tail = 0; occupancy = 0.
  - empty = 1, full = 0.
  - alloc_ready = 1, retire_ready = 0, err = 0.
- All state changes occur at the posedge clk after the handshake cycle.
- alloc_idx and retire_idx are stable through the whole handshake cycle and update one cycle after a fire.
- Zero-cycle latency from registered state to outputs. The only combinational input-to-output path is flush → alloc_ready/retire_ready.
- rst asserted mid-operation discards all allocations immediately, regardless of clk.
- Throughput: one alloc plus one retire per cycle, sustained indefinitely.

## Test plan
- Reset then fill, DEPTH=8: eight cycles of alloc_valid=1.
  - Required: alloc_idx reads 0..7.
  - After the 8th fire: full=1, alloc_ready=0, occupancy=8.
  - A 9th alloc_valid does not change head.
- Drain: from full, eight cycles of retire_valid=1.
  - Required: retire_idx reads 0..7; then empty=1, retire_ready=0, occupancy=0.
- Wrap, non-power-of-two DEPTH=5: 12 allocs interleaved with retires, keeping occupancy ≤3.
  - Required: alloc_idx sequence 0,1,2,3,4,0,1,2,3,4,0,1.
  - Invariant holds every cycle.
- Simultaneous events at occupancy=3 with alloc_valid=retire_valid=1 for 4 cycles.
  - Required: occupancy stays 3; head and tail each advance by 4 mod DEPTH.
  - At full with both asserted: only the retire fires, and occupancy drops to DEPTH-1.
- Flush mid-operation at occupancy=4, asserting flush together with alloc_valid and retire_valid.
  - Required in the flush cycle: alloc_ready=retire_ready=0.
  - Next cycle: head=tail=0, occupancy=0, empty=1.
  - An err value already set stays set.
- Error and async reset:
  - retire_valid while empty → err=1 next cycle; err stays 1 after a flush.
  - rst asserted between clock edges clears err and occupancy immediately.
  - DEPTH=1 run: alloc/retire alternation keeps both indices at 0.
